// File: rtl/umac_pkg.sv
// umac_pkg: state type, LFSR tap table and popcount
// shared by the scaled stochastic MAC and its lanes.
package umac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } umac_state_t;

  // Maximal-length Fibonacci taps, bit n-1 set for tap n.
  function automatic logic [15:0] lfsr_taps(input int w);
    logic [15:0] t;
    case (w)
      3:       t = 16'h0006;
      4:       t = 16'h000C;
      5:       t = 16'h0014;
      6:       t = 16'h0030;
      7:       t = 16'h0060;
      8:       t = 16'h00B8;
      9:       t = 16'h0110;
      10:      t = 16'h0240;
      11:      t = 16'h0500;
      12:      t = 16'h0829;
      13:      t = 16'h100D;
      14:      t = 16'h2015;
      15:      t = 16'h6000;
      default: t = 16'hD008;
    endcase
    return t;
  endfunction

  function automatic int popcount(input logic [255:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 256; i++) begin
      n += int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/umac_scaled_param_lane.sv
// umul_lane: one MAC lane. Holds weight wB, compares
// it against the lane RNG and multiplies with iA.
// Ports: clk, rst_n, we_i/wd_i (weight write),
//  a_i (unary bit), rng_i (rotated LFSR), m_o (product).
module umul_lane #(
  parameter int WIDTH   = 8,
  parameter int BIPOLAR = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [WIDTH-1:0] wd_i,
  input  logic             a_i,
  input  logic [WIDTH-1:0] rng_i,
  output logic             m_o
);

  logic [WIDTH-1:0] w_q;
  logic             b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q <= '0;
    end else if (we_i) begin
      w_q <= wd_i;
    end
  end

  assign b = (w_q > rng_i);

  if (BIPOLAR != 0) begin : g_bip
    assign m_o = ~(a_i ^ b);
  end else begin : g_uni
    assign m_o = a_i & b;
  end

endmodule

// File: rtl/umac_scaled_param.sv
// umac_scaled_param: NUM-lane stochastic MAC with 1/NUM
// scaled adder, windowed run control and ones counter.
// Ports: clk, rst_n (async, active low);
//  iA (lane bits); iB_data/iB_addr/iB_valid/iB_ready
//  (weight write, IDLE only); start (begin window);
//  oC/oC_valid (output stream); done (window end pulse);
//  count (ones on oC in last window).
module umac_scaled_param
  import umac_pkg::*;
#(
  parameter int               NUM     = 16,
  parameter int               WIDTH   = 8,
  parameter int               BIPOLAR = 1,
  parameter logic [WIDTH-1:0] SEED    = WIDTH'(1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM-1:0]          iA,
  input  logic [WIDTH-1:0]        iB_data,
  input  logic [$clog2(NUM)-1:0]  iB_addr,
  input  logic                    iB_valid,
  output logic                    iB_ready,
  input  logic                    start,
  output logic                    oC,
  output logic                    oC_valid,
  output logic                    done,
  output logic [WIDTH-1:0]        count
);

  localparam int AW = $clog2(NUM);
  localparam int CW = AW + 1;
  localparam logic [WIDTH-1:0] TAPS =
    WIDTH'(lfsr_taps(WIDTH));
  localparam logic [WIDTH-1:0] LAST =
    WIDTH'((1 << WIDTH) - 2);
  localparam logic [CW-1:0] NUMC = CW'(NUM);

  umac_state_t      state_q, state_d;
  logic [WIDTH-1:0] lfsr_q;
  logic [WIDTH-1:0] win_q;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] cnt_inc;
  logic [CW-1:0]    acc_q;
  logic [CW-1:0]    sum;
  logic [NUM-1:0]   m;
  logic             oc_q, ocv_q, done_q;
  logic             wr, ge;

  assign wr = (state_q == IDLE) && iB_valid;

  for (genvar i = 0; i < NUM; i++) begin : g_lane
    localparam int SH = i % WIDTH;
    logic [WIDTH-1:0] rng;
    if (SH == 0) begin : g_r0
      assign rng = lfsr_q;
    end else begin : g_rn
      assign rng = (lfsr_q << SH)
                 | (lfsr_q >> (WIDTH - SH));
    end
    // Addresses >= NUM match no lane: write dropped.
    umul_lane #(
      .WIDTH  (WIDTH),
      .BIPOLAR(BIPOLAR)
    ) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .we_i (wr && (iB_addr == AW'(i))),
      .wd_i (iB_data),
      .a_i  (iA[i]),
      .rng_i(rng),
      .m_o  (m[i])
    );
  end

  // acc < NUM and popcount <= NUM, so CW bits hold sum.
  assign sum     = acc_q + CW'(popcount(256'(m)));
  assign ge      = (sum >= NUMC);
  assign cnt_inc = cnt_q + WIDTH'(oc_q & ocv_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (win_q == LAST) state_d = DRAIN;
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lfsr_q  <= SEED;
      win_q   <= '0;
      acc_q   <= '0;
      oc_q    <= 1'b0;
      ocv_q   <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      oc_q    <= 1'b0;
      ocv_q   <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= cnt_inc;
      if (state_q == IDLE && start) begin
        cnt_q <= '0;
      end
      if (state_q == RUN) begin
        lfsr_q <= {lfsr_q[WIDTH-2:0],
                   ^(lfsr_q & TAPS)};
        win_q  <= (win_q == LAST) ? '0
                : win_q + 1'b1;
        acc_q  <= ge ? sum - NUMC : sum;
        oc_q   <= ge;
        ocv_q  <= 1'b1;
      end
      // Last stream bit is on oC during DRAIN.
      if (state_q == DRAIN) begin
        done_q  <= 1'b1;
        count_q <= cnt_inc;
      end
    end
  end

  assign iB_ready = (state_q == IDLE);
  assign oC       = oc_q;
  assign oC_valid = ocv_q;
  assign done     = done_q;
  assign count    = count_q;

endmodule

// File: tb/tb_umac_scaled_param.sv
// tb_umac_scaled_param: random and directed windows on
// three MAC variants against a window-level model.
module tb_umac_scaled_param;

  localparam int ND = 3;

  logic        clk;
  logic        rst_n;
  logic [15:0] iA;
  logic [7:0]  iB_data;
  logic [3:0]  iB_addr;
  logic        iB_valid;
  logic        start;
  logic        rdy [ND];
  logic        oc  [ND];
  logic        ocv [ND];
  logic        dn  [ND];
  logic [7:0]  cnt [ND];

  int n_chk = 0;
  int n_err = 0;

  int numd [ND] = '{16, 16, 12};
  int bipd [ND] = '{1, 0, 0};
  int wt   [ND][16];
  int accm [ND];
  int expc [ND];
  int gotc [ND];
  bit expb [ND][255];
  int rng  [255];
  logic [15:0] ia [255];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  umac_scaled_param #(
    .NUM(16), .WIDTH(8), .BIPOLAR(1), .SEED(8'h01)
  ) u_bip (
    .clk(clk), .rst_n(rst_n), .iA(iA),
    .iB_data(iB_data), .iB_addr(iB_addr),
    .iB_valid(iB_valid), .iB_ready(rdy[0]),
    .start(start), .oC(oc[0]), .oC_valid(ocv[0]),
    .done(dn[0]), .count(cnt[0])
  );

  umac_scaled_param #(
    .NUM(16), .WIDTH(8), .BIPOLAR(0), .SEED(8'h01)
  ) u_uni (
    .clk(clk), .rst_n(rst_n), .iA(iA),
    .iB_data(iB_data), .iB_addr(iB_addr),
    .iB_valid(iB_valid), .iB_ready(rdy[1]),
    .start(start), .oC(oc[1]), .oC_valid(ocv[1]),
    .done(dn[1]), .count(cnt[1])
  );

  umac_scaled_param #(
    .NUM(12), .WIDTH(8), .BIPOLAR(0), .SEED(8'h01)
  ) u_n12 (
    .clk(clk), .rst_n(rst_n), .iA(iA[11:0]),
    .iB_data(iB_data), .iB_addr(iB_addr),
    .iB_valid(iB_valid), .iB_ready(rdy[2]),
    .start(start), .oC(oc[2]), .oC_valid(ocv[2]),
    .done(dn[2]), .count(cnt[2])
  );

  task automatic chk(input string tag,
                     input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got %0d want %0d",
               tag, got, exp);
    end
  endtask

  function automatic int rotl8(input int v,
                               input int s);
    return ((v << s) | (v >> (8 - s))) & 255;
  endfunction

  // x^8+x^6+x^5+x^4+1 sequence from seed 1.
  task automatic build_rng();
    int v;
    int fb;
    v = 1;
    for (int k = 0; k < 255; k++) begin
      rng[k] = v;
      fb = ((v >> 7) ^ (v >> 5) ^ (v >> 4)
           ^ (v >> 3)) & 1;
      v = ((v << 1) | fb) & 255;
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < ND; d++) begin
      accm[d] = 0;
      for (int i = 0; i < 16; i++) wt[d][i] = 0;
    end
  endtask

  task automatic model_win();
    for (int d = 0; d < ND; d++) begin
      int ones;
      ones = 0;
      for (int k = 0; k < 255; k++) begin
        int s;
        s = accm[d];
        for (int i = 0; i < numd[d]; i++) begin
          bit a;
          bit b;
          bit p;
          a = ia[k][i];
          b = wt[d][i] > rotl8(rng[k], i % 8);
          p = (bipd[d] != 0) ? (a == b) : (a & b);
          s += int'(p);
        end
        if (s >= numd[d]) begin
          expb[d][k] = 1'b1;
          ones++;
          accm[d] = s - numd[d];
        end else begin
          expb[d][k] = 1'b0;
          accm[d] = s;
        end
      end
      expc[d] = ones;
    end
  endtask

  task automatic set_w(input int a, input int v);
    for (int d = 0; d < ND; d++) begin
      if (a < numd[d]) wt[d][a] = v;
    end
  endtask

  task automatic load_w(input int a, input int v);
    @(negedge clk);
    iB_valid = 1'b1;
    iB_addr  = a[3:0];
    iB_data  = v[7:0];
    set_w(a, v);
    @(negedge clk);
    iB_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n    = 1'b1;
    iA       = '0;
    iB_valid = 1'b0;
    iB_addr  = '0;
    iB_data  = '0;
    start    = 1'b0;
    #2 rst_n = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("rst_oc_d%0d", d), oc[d], 0);
      chk($sformatf("rst_ocv_d%0d", d), ocv[d], 0);
      chk($sformatf("rst_done_d%0d", d), dn[d], 0);
      chk($sformatf("rst_cnt_d%0d", d), cnt[d], 0);
      chk($sformatf("rst_rdy_d%0d", d), rdy[d], 1);
    end
    rst_n = 1'b1;
  endtask

  task automatic run_win(input string nm,
                         input logic [15:0] pat,
                         input bit rnd,
                         input bit wr,
                         input int wa, input int wv,
                         input bit poke);
    int bad [ND];
    int nv  [ND];
    int nd  [ND];
    int idv;
    for (int k = 0; k < 255; k++) begin
      ia[k] = rnd ? 16'($urandom) : pat;
    end
    @(negedge clk);
    start = 1'b1;
    if (wr) begin
      iB_valid = 1'b1;
      iB_addr  = wa[3:0];
      iB_data  = wv[7:0];
      set_w(wa, wv);
    end
    model_win();
    @(negedge clk);
    start    = 1'b0;
    iB_valid = 1'b0;
    iA       = ia[0];
    chk({nm, "_lat"}, ocv[0], 0);
    for (int d = 0; d < ND; d++) begin
      bad[d] = 0;
      nv[d]  = 0;
      nd[d]  = 0;
    end
    for (int k = 0; k < 255; k++) begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        nv[d] += int'(ocv[d]);
        if (dn[d]) nd[d]++;
        if (oc[d] !== expb[d][k]) bad[d]++;
      end
      if (k < 254) iA = ia[k + 1];
      if (poke && k == 100) begin
        start    = 1'b1;
        iB_valid = 1'b1;
        iB_addr  = 4'd0;
        iB_data  = 8'h5A;
        for (int d = 0; d < ND; d++) begin
          chk($sformatf("%s_rdy_run_d%0d", nm, d),
              rdy[d], 0);
        end
      end
      if (poke && k == 101) begin
        start    = 1'b0;
        iB_valid = 1'b0;
      end
    end
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("%s_stream_d%0d", nm, d),
          bad[d], 0);
      chk($sformatf("%s_nvalid_d%0d", nm, d),
          nv[d], 255);
      chk($sformatf("%s_early_done_d%0d", nm, d),
          nd[d], 0);
      chk($sformatf("%s_done_d%0d", nm, d), dn[d], 1);
      chk($sformatf("%s_ocv_off_d%0d", nm, d),
          ocv[d], 0);
      chk($sformatf("%s_cnt_d%0d", nm, d),
          cnt[d], expc[d]);
      gotc[d] = int'(cnt[d]);
    end
    idv = 0;
    @(negedge clk);
    chk({nm, "_done_pulse"}, dn[0], 0);
    repeat (4) begin
      for (int d = 0; d < ND; d++) begin
        idv += int'(ocv[d]) + int'(dn[d]);
      end
      @(negedge clk);
    end
    chk({nm, "_idle_quiet"}, idv, 0);
    chk({nm, "_cnt_held"}, cnt[1], gotc[1]);
  endtask

  task automatic mid_reset();
    int act;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) begin
      iA = 16'($urandom);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("mrst_oc_d%0d", d), oc[d], 0);
      chk($sformatf("mrst_ocv_d%0d", d), ocv[d], 0);
      chk($sformatf("mrst_cnt_d%0d", d), cnt[d], 0);
      chk($sformatf("mrst_rdy_d%0d", d), rdy[d], 1);
    end
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    act = 0;
    repeat (300) begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        act += int'(dn[d]) + int'(ocv[d]);
      end
    end
    chk("mrst_no_done", act, 0);
  endtask

  initial begin
    int pair;
    build_rng();
    do_reset();

    // All-zero weights, iA=0 then iA=1.
    run_win("t1", 16'h0000, 1'b0, 1'b0, 0, 0, 1'b0);
    chk("t1_bip_full", gotc[0], 255);
    run_win("t2", 16'hFFFF, 1'b0, 1'b0, 0, 0, 1'b0);
    chk("t2_bip_zero", gotc[0], 0);

    // Full weights; n12 drops addresses 12..15.
    for (int a = 0; a < 16; a++) load_w(a, 255);
    run_win("t3", 16'hFFFF, 1'b0, 1'b0, 0, 0, 1'b0);
    chk("t3_uni_254",
        int'(gotc[1] >= 253 && gotc[1] <= 255), 1);
    run_win("t2b", 16'h0000, 1'b0, 1'b0, 0, 0, 1'b0);
    chk("t2b_uni_zero", gotc[1], 0);

    // Half lanes on; residue carries across windows.
    for (int a = 8; a < 16; a++) load_w(a, 0);
    run_win("t4a", 16'hFFFF, 1'b0, 1'b0, 0, 0, 1'b0);
    pair = gotc[1];
    chk("t4a_half",
        int'(gotc[1] >= 126 && gotc[1] <= 128), 1);
    run_win("t4b", 16'hFFFF, 1'b0, 1'b0, 0, 0, 1'b0);
    pair += gotc[1];
    chk("t4_pair", int'(pair >= 253 && pair <= 255), 1);

    // Write with start, pokes during RUN.
    for (int a = 0; a < 16; a++) load_w(a, $urandom_range(0, 255));
    run_win("t5a", 16'h0, 1'b1, 1'b1, 3,
            $urandom_range(0, 255), 1'b1);
    run_win("t5b", 16'h0, 1'b1, 1'b0, 0, 0, 1'b0);

    for (int r = 0; r < 3; r++) begin
      for (int a = 0; a < 16; a++) begin
        load_w(a, $urandom_range(0, 255));
      end
      run_win($sformatf("rnd%0d", r), 16'h0, 1'b1,
              1'b0, 0, 0, 1'b0);
    end

    // Reset in RUN, then out-of-range-only weights.
    mid_reset();
    for (int a = 12; a < 16; a++) load_w(a, 255);
    run_win("t6a", 16'hFFFF, 1'b0, 1'b0, 0, 0, 1'b0);
    chk("t6a_n12_drop", gotc[2], 0);
    for (int a = 0; a < 16; a++) load_w(a, $urandom_range(0, 255));
    run_win("t6b", 16'h0, 1'b1, 1'b0, 0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
